ifft_output_buffer: RTL



---
 rtl/audio_pkg.sv | 31 +++
 rtl/obuf_line_ram.sv | 44 ++++
 rtl/ifft_output_buffer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pkg
//  Description : Shared constants and types for the audio output capture path
//                (frame geometry, line geometry, capture state encoding).
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

  // Frame and line geometry
  localparam int SIZE             = 16;
  localparam int INPUT_SIZE       = 512;
  localparam int SAMPLES          = 2048;
  localparam int LINES            = SAMPLES * SIZE / INPUT_SIZE;
  localparam int SAMPLES_PER_LINE = INPUT_SIZE / SIZE;

  // Derived index widths
  localparam int LINE_W = $clog2(LINES);
  localparam int CNT_W  = $clog2(SAMPLES);
  localparam int SLOT_W = $clog2(SAMPLES_PER_LINE);

  // Capture controller states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } obuf_state_t;

endpackage
`default_nettype wire

// File: rtl/obuf_line_ram.sv
`default_nettype none
// ============================================================================
//  Module      : obuf_line_ram
//  Description : LINES x INPUT_SIZE line store, one write port and one
//                registered read port. Read-before-write on an address
//                collision. Storage is never reset so it maps to block RAM;
//                only the read register is cleared.
//  Revision    : 1.0 - initial release
// ============================================================================
module obuf_line_ram
  import audio_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [LINE_W-1:0]     waddr_i,
  input  logic [INPUT_SIZE-1:0] wdata_i,
  input  logic [LINE_W-1:0]     raddr_i,
  output logic [INPUT_SIZE-1:0] rdata_o
);

  logic [INPUT_SIZE-1:0] mem_q [LINES];
  logic [INPUT_SIZE-1:0] rdata_q;

  // Line write; storage contents survive reset
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read; a same-edge write is not visible until the next read
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/ifft_output_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : ifft_output_buffer
//  Description : Captures one frame of SAMPLES complex samples, keeps the
//                scaled real part and packs SAMPLES_PER_LINE samples per
//                INPUT_SIZE-bit line (sample 0 in the LSBs). Lines are read
//                back by index with one cycle of latency.
//  Options     : OBUF_SAT_EN - saturate the gain-shifted real part to the
//                signed SIZE-bit range instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifft_output_buffer
  import audio_pkg::*;
#(
  parameter int GAIN_SHIFT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sample_valid,
  input  logic                  sample_sync,
  input  logic [31:0]           sample_in,
  input  logic [LINE_W-1:0]     output_index,
  output logic [INPUT_SIZE-1:0] data_out,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int WIDE   = SIZE + GAIN_SHIFT;
  localparam int HOLD_W = (SAMPLES_PER_LINE - 1) * SIZE;

  obuf_state_t           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;

  logic signed [SIZE-1:0] w_real;
  logic signed [WIDE-1:0] w_wide;
  logic [SIZE-1:0]        w_sample;
  logic [SLOT_W-1:0]      w_slot;
  logic [LINE_W-1:0]      w_line;
  logic                   w_accept;
  logic                   w_start_ok;
  logic                   w_last_slot;
  logic                   w_last_sample;
  logic                   w_unused_imag;

  // ---------------------------------------------------------------- sample path
  assign w_real        = sample_in[31:16];
  assign w_unused_imag = ^sample_in[15:0];
  assign w_wide        = WIDE'(w_real) <<< GAIN_SHIFT;

`ifdef OBUF_SAT_EN
  // Overflow when the bits above the kept sign bit disagree with it
  logic [GAIN_SHIFT:0] w_top;
  logic                w_ovf;
  assign w_top    = w_wide[WIDE-1:SIZE-1];
  assign w_ovf    = ~((&w_top) | ~(|w_top));
  assign w_sample = !w_ovf          ? w_wide[SIZE-1:0] :
                    w_wide[WIDE-1]  ? {1'b1, {(SIZE-1){1'b0}}} :
                                      {1'b0, {(SIZE-1){1'b1}}};
`else
  assign w_sample = w_wide[SIZE-1:0];
`endif

  // ---------------------------------------------------------------- control
  assign w_slot        = cnt_q[SLOT_W-1:0];
  assign w_line        = cnt_q[CNT_W-1:SLOT_W];
  assign w_last_slot   = &w_slot;
  assign w_last_sample = &cnt_q;
  assign w_accept      = sample_valid &
                         (((state_q == ARMED) & sample_sync) | (state_q == CAPTURE));
  assign w_start_ok    = start & ((state_q == IDLE) | (state_q == DONE));

  // State, sample counter and holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state decode: sync only matters in ARMED, start only in IDLE/DONE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)                          state_d = ARMED;
      ARMED:   if (w_accept)                       state_d = CAPTURE;
      CAPTURE: if (w_accept && w_last_sample)      state_d = DONE;
      DONE:    if (start)                          state_d = ARMED;
      default:                                     state_d = IDLE;
    endcase
  end

  // Counter advance and slot collection; slot 31 goes straight to memory
  always_comb begin
    cnt_d  = cnt_q;
    hold_d = hold_q;
    if (w_accept) begin
      cnt_d = cnt_q + 1'b1;
      if (!w_last_slot) begin
        hold_d[int'(w_slot)*SIZE +: SIZE] = w_sample;
      end
    end
    if (w_start_ok) begin
      cnt_d = '0;
    end
  end

  // ---------------------------------------------------------------- storage
  obuf_line_ram u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (w_accept & w_last_slot),
    .waddr_i (w_line),
    .wdata_i ({w_sample, hold_q}),
    .raddr_i (output_index),
    .rdata_o (data_out)
  );

  assign busy_o = (state_q == ARMED) | (state_q == CAPTURE);
  assign done_o = (state_q == DONE);

endmodule
`default_nettype wire
